// File: rtl/wave_capture.sv
// Purpose : audio-side writer for the double-buffered 512x8 waveform RAM; captures 256
//           samples after a positive zero crossing into the half the display is not reading.
// Latency : 1 cycle from an accepted new_sample_ready to the registered RAM write.
// Backpressure: none; every strobe is consumed, and strobes arriving outside a capture
//           only refresh the zero-crossing history.
//
// Ports:
//   clk               system clock
//   reset             synchronous, active-low (0 = reset)
//   new_sample_ready  one-cycle strobe qualifying new_sample_in (may repeat back-to-back)
//   new_sample_in     signed two's-complement audio sample
//   wave_display_idle high while the display is in blanking
//   write_address     {half, index[7:0]} RAM write address
//   write_enable      one-cycle RAM write strobe per stored sample
//   write_sample      top 8 bits of the sample in offset binary
//   read_index        RAM half the display reads; writes go to the other half

module wave_capture #(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_sample_ready,
    input  logic [SAMPLE_W-1:0] new_sample_in,
    input  logic                wave_display_idle,
    output logic [8:0]          write_address,
    output logic                write_enable,
    output logic [7:0]          write_sample,
    output logic                read_index
);

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          count;
    logic [7:0]          count_nxt;
    logic [SAMPLE_W-1:0] prev;
    logic                idle_d;
    logic                read_index_nxt;
    logic                write_enable_nxt;
    logic [8:0]          write_address_nxt;
    logic [7:0]          write_sample_nxt;

    logic                trigger;
    logic                idle_rise;
    logic [7:0]          sample_ob;

    // Only the top byte of each sample is stored; the low bits are intentionally dropped.
    logic                unused_low_bits;
    assign unused_low_bits = ^new_sample_in[SAMPLE_W-9:0];

    // Positive zero crossing: previous sample negative, current one non-negative.
    assign trigger   = new_sample_ready & prev[SAMPLE_W-1] & ~new_sample_in[SAMPLE_W-1];

    // Only a rising edge of blanking may swap halves, so a display that is already
    // idle when the capture completes has to leave and re-enter blanking first.
    assign idle_rise = wave_display_idle & ~idle_d;

    // Offset binary: invert the sign bit of the top byte (equivalent to adding 128).
    assign sample_ob = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2 -: 7]};

    always_comb begin
        state_nxt         = state;
        count_nxt         = count;
        read_index_nxt    = read_index;
        write_enable_nxt  = 1'b0;
        write_address_nxt = write_address;
        write_sample_nxt  = write_sample;

        case (state)
            ARMED: begin
                if (trigger) begin
                    write_enable_nxt  = 1'b1;
                    write_address_nxt = {~read_index, 8'd0};
                    write_sample_nxt  = sample_ob;
                    count_nxt         = 8'd1;
                    state_nxt         = ACTIVE;
                end
            end
            ACTIVE: begin
                if (new_sample_ready) begin
                    write_enable_nxt  = 1'b1;
                    write_address_nxt = {~read_index, count};
                    write_sample_nxt  = sample_ob;
                    // Index 255 is the last one; count wraps back to 0 on its own.
                    count_nxt         = count + 8'd1;
                    if (count == 8'hFF) begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (idle_rise) begin
                    read_index_nxt = ~read_index;
                    state_nxt      = ARMED;
                end
            end
            default: begin
                state_nxt = ARMED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ARMED;
            count         <= 8'd0;
            prev          <= '0;
            idle_d        <= 1'b1;
            read_index    <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= 9'd0;
            write_sample  <= 8'd0;
        end else begin
            state         <= state_nxt;
            count         <= count_nxt;
            idle_d        <= wave_display_idle;
            read_index    <= read_index_nxt;
            write_enable  <= write_enable_nxt;
            write_address <= write_address_nxt;
            write_sample  <= write_sample_nxt;
            // History is kept in every state so a crossing spanning WAIT->ARMED still triggers.
            if (new_sample_ready) begin
                prev <= new_sample_in;
            end
        end
    end

endmodule

// File: tb/tb_wave_capture.sv
module tb_wave_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        new_sample_ready = 1'b0;
    logic [15:0] new_sample_in = 16'd0;
    logic        wave_display_idle = 1'b0;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    int checks = 0;
    int errors = 0;
    int dut_writes = 0;

    wave_capture #(.SAMPLE_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .new_sample_ready (new_sample_ready),
        .new_sample_in    (new_sample_in),
        .wave_display_idle(wave_display_idle),
        .write_address    (write_address),
        .write_enable     (write_enable),
        .write_sample     (write_sample),
        .read_index       (read_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: "filled" is how many samples of the current capture are stored
    // (0 = waiting for a crossing, 256 = full and waiting for the display to swap).
    int          m_filled   = 0;
    logic        m_rd       = 1'b0;
    logic [15:0] m_prev     = 16'd0;
    logic        m_idle_old = 1'b1;
    logic        e_we       = 1'b0;
    logic [8:0]  e_addr     = 9'd0;
    logic [7:0]  e_dat      = 8'd0;

    always @(posedge clk) begin
        if (!reset) begin
            m_filled = 0; m_rd = 1'b0; m_prev = 16'd0; m_idle_old = 1'b1;
            e_we = 1'b0; e_addr = 9'd0; e_dat = 8'd0;
        end else begin
            bit was_full;
            bit store;
            was_full = (m_filled == 256);
            e_we = 1'b0;
            if (new_sample_ready) begin
                store = (m_filled == 0 && $signed(m_prev) < 0 && $signed(new_sample_in) >= 0)
                     || (m_filled > 0 && m_filled < 256);
                if (store) begin
                    e_we   = 1'b1;
                    e_addr = {~m_rd, 8'(m_filled)};
                    e_dat  = new_sample_in[15:8] ^ 8'h80;
                    m_filled++;
                end
                m_prev = new_sample_in;
            end
            if (was_full && wave_display_idle && !m_idle_old) begin
                m_rd = ~m_rd;
                m_filled = 0;
            end
            m_idle_old = wave_display_idle;
        end
        #1;
        chk("write_enable", 16'(write_enable), 16'(e_we));
        chk("write_address", 16'(write_address), 16'(e_addr));
        chk("write_sample", 16'(write_sample), 16'(e_dat));
        chk("read_index", 16'(read_index), 16'(m_rd));
    end

    always @(posedge clk) begin
        #1;
        if (write_enable === 1'b1) dut_writes++;
    end

    task automatic put(input logic r, input logic [15:0] s);
        @(negedge clk);
        new_sample_ready = r;
        new_sample_in    = s;
    endtask

    // Single strobe; returns at the negedge where its write (if any) is visible.
    task automatic strobe(input logic [15:0] s);
        put(1'b1, s);
        put(1'b0, s);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) put(1'b0, new_sample_in);
    endtask

    // Random-sample strobes, roughly a third of them back-to-back.
    task automatic capture_strobes(input int n);
        for (int i = 0; i < n; i++) begin
            put(1'b1, 16'($urandom));
            if ($urandom_range(0, 2) != 0) put(1'b0, 16'd0);
        end
        put(1'b0, 16'd0);
    endtask

    initial begin
        int base;

        // Reset held with strobes and idle toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            new_sample_ready  = 1'b1;
            new_sample_in     = (i % 2 == 0) ? 16'hFF9C : 16'h0032;
            wave_display_idle = ~wave_display_idle;
        end
        @(negedge clk);
        new_sample_ready = 1'b0;
        chk("reset_we", 16'(write_enable), 16'd0);
        chk("reset_addr", 16'(write_address), 16'd0);
        chk("reset_dat", 16'(write_sample), 16'd0);
        chk("reset_rd", 16'(read_index), 16'd0);
        reset = 1'b1;
        wave_display_idle = 1'b0;
        idle_cycles(2);

        // Trigger on -100 -> +50, then -256.
        base = dut_writes;
        strobe(16'hFF9C);
        strobe(16'h0032);
        chk("trig_we", 16'(write_enable), 16'd1);
        chk("trig_addr", 16'(write_address), 16'h100);
        chk("trig_dat", 16'(write_sample), 16'h80);
        strobe(16'hFF00);
        chk("second_addr", 16'(write_address), 16'h101);
        chk("second_dat", 16'(write_sample), 16'h7F);

        // Complete the capture, then extra strobes must not write.
        capture_strobes(254);
        idle_cycles(2);
        chk("full_count", 16'(dut_writes - base), 16'd256);
        capture_strobes(10);
        idle_cycles(2);
        chk("wait_no_write", 16'(dut_writes - base), 16'd256);
        chk("wait_rd", 16'(read_index), 16'd0);
        wave_display_idle = 1'b1;
        idle_cycles(1);
        chk("flip_rd", 16'(read_index), 16'd1);
        strobe(16'hFFFF);
        strobe(16'h1234);
        chk("half0_addr", 16'(write_address), 16'h000);
        chk("half0_dat", 16'(write_sample), 16'h92);

        // No trigger: samples decreasing from +150 through zero to -149.
        reset = 1'b0;
        idle_cycles(2);
        reset = 1'b1;
        wave_display_idle = 1'b0;
        idle_cycles(1);
        base = dut_writes;
        for (int i = 0; i < 300; i++) put(1'b1, 16'(150 - i));
        idle_cycles(2);
        chk("no_trigger", 16'(dut_writes - base), 16'd0);

        // Still armed: next crossing starts a capture, with idle held high throughout.
        wave_display_idle = 1'b1;
        strobe(16'h0005);
        chk("armed_trig_addr", 16'(write_address), 16'h100);
        capture_strobes(255);
        idle_cycles(4);
        chk("level_count", 16'(dut_writes - base), 16'd256);
        chk("level_no_flip", 16'(read_index), 16'd0);
        wave_display_idle = 1'b0;
        idle_cycles(2);
        wave_display_idle = 1'b1;
        chk("pre_rise_rd", 16'(read_index), 16'd0);
        idle_cycles(1);
        chk("rise_flip_rd", 16'(read_index), 16'd1);
        idle_cycles(3);
        chk("single_flip_rd", 16'(read_index), 16'd1);

        // Reset after 100 writes of a capture into half 0.
        base = dut_writes;
        strobe(16'hFFFB);
        strobe(16'h0005);
        chk("mid_trig_addr", 16'(write_address), 16'h000);
        capture_strobes(99);
        chk("mid_count", 16'(dut_writes - base), 16'd100);
        reset = 1'b0;
        idle_cycles(2);
        chk("mid_reset_rd", 16'(read_index), 16'd0);
        reset = 1'b1;
        idle_cycles(1);
        strobe(16'hFFFB);
        strobe(16'h0005);
        chk("post_reset_addr", 16'(write_address), 16'h100);

        // Randomized traffic; the per-cycle model check does the work here.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            new_sample_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) new_sample_in = 16'($urandom);
            else new_sample_in = 16'($signed(16'($urandom_range(0, 200))) - 16'sd100);
            if ($urandom_range(0, 19) == 0) wave_display_idle = ~wave_display_idle;
            reset = ($urandom_range(0, 799) != 0);
        end
        reset = 1'b1;
        idle_cycles(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_capture.md
# wave_capture

Audio-side writer for the double-buffered waveform RAM that the note/wave display reads. Arms on a positive zero crossing of the incoming signed audio stream, writes 256 consecutive samples, converted to 8-bit offset-binary, into the RAM half the display is not reading, then waits for display blanking to swap halves via `read_index`. Sits between the codec/sample source and the 512x8 sample RAM, and drives the display's `read_index` input.

## Interface
- `SAMPLE_W`, 16: width of signed input sample, two's complement.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-low; 0 = reset.
- `new_sample_ready` input 1: one-cycle strobe, `new_sample_in` valid; may assert on back-to-back cycles.
- `new_sample_in` input SAMPLE_W: signed audio sample.
- `wave_display_idle` input 1: high while the display is outside the drawn region (blanking).
- `write_address` output 9: RAM write address {half, index[7:0]}.
- `write_enable` output 1: RAM write strobe, one cycle per stored sample.
- `write_sample` output 8: offset-binary sample, `new_sample_in[SAMPLE_W-1:SAMPLE_W-8]` with MSB inverted (adds 128).
- `read_index` output 1: RAM half the display reads; writes always target `~read_index`.

## Operation
- State machine: ARMED, ACTIVE, WAIT. Internal 8-bit `count`, sample register `prev`, idle-delay register `idle_d`.
- `prev` <= `new_sample_in` on every `new_sample_ready`, in every state.
- ARMED: on `new_sample_ready` with `prev` negative (MSB 1) and `new_sample_in` non-negative (MSB 0), the trigger sample is written at index 0, `count` <= 1, go ACTIVE. Otherwise no write.
- ACTIVE: each `new_sample_ready` writes at index `count`, `count` increments. The write at index 255 goes to WAIT, `count` wraps to 0.
- WAIT: samples are ignored except for the `prev` update. On rising edge of `wave_display_idle` (`wave_display_idle` & ~`idle_d`): `read_index` toggles, go ARMED.
- Flip only on rising edge: idle already high on entry to WAIT does not flip until it falls and rises again.
- Exactly 256 writes per capture, contiguous indices 0..255, all in the same half.
- Reset mid-capture aborts it. The partial half is discarded and `read_index` returns to 0.

## Timing
- Reset values: state ARMED, `count` 0, `prev` 0, `idle_d` 1, `read_index` 0, `write_enable` 0, `write_address` 0, `write_sample` 0.
- Outputs are registered. `write_enable`/`write_address`/`write_sample` are valid in the cycle after the accepting `new_sample_ready`. Latency 1. `write_address` and `write_sample` hold their values while `write_enable` is 0.
- Back-to-back strobes produce back-to-back writes at consecutive addresses.
- `write_address[8]` = `~read_index` as sampled in the accepting cycle.
- `read_index` changes in the cycle after the idle rising edge. A strobe in the flip cycle is not written; it updates `prev` only.
- The first trigger is possible on the first strobe after returning to ARMED, using the `prev` captured during WAIT.
- The idle edge is ignored outside WAIT.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with strobes and idle toggling -> all outputs at reset values, no `write_enable`.
- Trigger: strobes -100 then +50 (0x0032) -> one cycle later, `write_enable`=1, `write_address`=0x100, `write_sample`=0x80. Next strobe of -256 (0xFF00) -> address 0x101, data 0x7F.
- Full capture: trigger, then 255 more strobes, some back-to-back -> exactly 256 writes at 0x100..0x1FF. Further strobes give no writes. Idle 0->1 -> `read_index`=1. Next trigger writes from 0x000.
- No trigger: 300 strobes, all positive or monotonically decreasing through zero -> zero writes, state stays ARMED.
- Idle level: `wave_display_idle` held 1 before and through entry to WAIT -> no flip. Drop to 0, raise to 1 -> single flip one cycle after the rise.
- Reset mid-ACTIVE after 100 writes -> `read_index`=0, ARMED. The next trigger writes from 0x100.
